// File: rtl/conv_filter_scheduler.sv
// Layer sequencer: one conv pass per filter, with bank select, conv handshake and result-RAM addressing.
// Optional watchdog enabled by defining CONV_TIMEOUT_EN.
module conv_filter_scheduler #(
  parameter int unsigned NUM_FILTERS  = 8,
  parameter int unsigned FILT_W       = 3,
  parameter int unsigned KERNEL_SIZE  = 9,
  parameter int unsigned WBASE_W      = 7,
  parameter int unsigned OUT_MAP_SIZE = 676,
  parameter int unsigned RES_ADDR_W   = 13
`ifdef CONV_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC  = 4096
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_layer,
  input  logic                  conv_latch_result,
  input  logic                  conv_final_done,
  output logic                  conv_start,
  output logic [FILT_W-1:0]     filter_sel,
  output logic [WBASE_W-1:0]    weight_base,
  output logic                  res_wr_en,
  output logic [RES_ADDR_W-1:0] res_wr_addr,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  err_count,
  output logic                  err_timeout
);

  localparam int unsigned PIX_W    = $clog2(OUT_MAP_SIZE + 1);
  localparam int unsigned MAX_ADDR = NUM_FILTERS * OUT_MAP_SIZE - 1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_RELEASE, S_DONE} state_t;

  state_t                state, state_next;
  logic [PIX_W-1:0]      pix_cnt, pix_cnt_next;
  logic [FILT_W-1:0]     filter_sel_next;
  logic [WBASE_W-1:0]    weight_base_next;
  logic [RES_ADDR_W-1:0] res_wr_addr_next;
  logic                  err_count_next;
  logic                  err_timeout_next;
  logic                  wr;

  assign wr        = (state == S_RUN) && conv_latch_result;
  assign res_wr_en = wr;

`ifdef CONV_TIMEOUT_EN
  logic [12:0] wd_cnt, wd_cnt_next;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_next       = state;
    pix_cnt_next     = pix_cnt;
    filter_sel_next  = filter_sel;
    weight_base_next = weight_base;
    res_wr_addr_next = res_wr_addr;
    err_count_next   = err_count;
    err_timeout_next = err_timeout;
`ifdef CONV_TIMEOUT_EN
    wd_cnt_next      = '0;
    if (state == S_RUN && !conv_latch_result) wd_cnt_next = wd_cnt + 13'(1);
`endif

    // Saturated pass keeps writing at the held address and flags the overrun
    if (wr) begin
      if (pix_cnt != PIX_W'(OUT_MAP_SIZE)) begin
        pix_cnt_next = pix_cnt + PIX_W'(1);
        if (res_wr_addr != RES_ADDR_W'(MAX_ADDR)) res_wr_addr_next = res_wr_addr + RES_ADDR_W'(1);
      end else begin
        err_count_next = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        if (start_layer) begin
          state_next       = S_ARM;
          filter_sel_next  = '0;
          weight_base_next = '0;
          pix_cnt_next     = '0;
          res_wr_addr_next = '0;
          err_count_next   = 1'b0;
          err_timeout_next = 1'b0;
        end
      end
      S_ARM: state_next = S_RUN;
      S_RUN: begin
        if (conv_final_done) begin
          state_next = S_RELEASE;
          if (pix_cnt_next != PIX_W'(OUT_MAP_SIZE)) err_count_next = 1'b1;
        end
`ifdef CONV_TIMEOUT_EN
        else if (!conv_latch_result && wd_cnt == 13'(TIMEOUT_CYC - 1)) begin
          state_next       = S_DONE;
          err_timeout_next = 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (!conv_final_done) begin
          if (filter_sel == FILT_W'(NUM_FILTERS - 1)) begin
            state_next = S_DONE;
          end else begin
            state_next       = S_ARM;
            filter_sel_next  = filter_sel + FILT_W'(1);
            weight_base_next = weight_base + WBASE_W'(KERNEL_SIZE);
            pix_cnt_next     = '0;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pix_cnt     <= '0;
      filter_sel  <= '0;
      weight_base <= '0;
      res_wr_addr <= '0;
      conv_start  <= 1'b0;
      busy        <= 1'b0;
      layer_done  <= 1'b0;
      err_count   <= 1'b0;
    end else begin
      state       <= state_next;
      pix_cnt     <= pix_cnt_next;
      filter_sel  <= filter_sel_next;
      weight_base <= weight_base_next;
      res_wr_addr <= res_wr_addr_next;
      conv_start  <= (state_next == S_RUN);
      busy        <= (state_next != S_IDLE);
      layer_done  <= (state_next == S_DONE);
      err_count   <= err_count_next;
    end
  end

`ifdef CONV_TIMEOUT_EN
  // Watchdog counts stalled RUN cycles since entry or the last result
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= wd_cnt_next;
      err_timeout <= err_timeout_next;
    end
  end
`else
  assign err_timeout = 1'b0;
  logic unused_err_timeout_next;
  assign unused_err_timeout_next = err_timeout_next;
`endif

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Bench for conv_filter_scheduler: behavioural conv FSM driver plus a write-count reference model.
module tb_conv_filter_scheduler;

  localparam int NF   = 8;
  localparam int OMS  = 676;
  localparam int KS   = 9;
  localparam int MAXA = NF * OMS - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_layer;
  logic        conv_latch_result;
  logic        conv_final_done;
  logic        conv_start;
  logic [2:0]  filter_sel;
  logic [6:0]  weight_base;
  logic        res_wr_en;
  logic [12:0] res_wr_addr;
  logic        busy;
  logic        layer_done;
  logic        err_count;
  logic        err_timeout;

  int checks = 0;
  int failures = 0;
  int exp_addr;
  int pix;
  bit exp_err;
  int gap;
  int done_cnt;
  int run_cyc;
  bit pulse_en;

  conv_filter_scheduler dut (
    .clk(clk), .reset(reset), .start_layer(start_layer),
    .conv_latch_result(conv_latch_result), .conv_final_done(conv_final_done),
    .conv_start(conv_start), .filter_sel(filter_sel), .weight_base(weight_base),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .busy(busy),
    .layer_done(layer_done), .err_count(err_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Advance one cycle; stray start_layer pulses are injected here when enabled
  task automatic tick();
    @(posedge clk);
    #1;
    run_cyc++;
    start_layer = pulse_en && (run_cyc == 100 || run_cyc == 3000);
    if (layer_done === 1'b1) done_cnt++;
  endtask

  task automatic start_run();
    exp_addr    = 0;
    exp_err     = 1'b0;
    done_cnt    = 0;
    gap         = 0;
    start_layer = 1'b1;
    tick();
    chk("busy_after_start", 32'(busy), 1);
    chk("conv_start_in_arm", 32'(conv_start), 0);
  endtask

  // One conv pass: n results, final_done optionally coincident with the last one
  task automatic run_pass(input int f, input int n, input bit fd_last, input bit abort);
    for (int i = 0; i < 20 && conv_start !== 1'b1; i++) begin
      gap++;
      tick();
    end
    if (conv_start !== 1'b1) begin
      bound_fail("conv_start_wait");
      return;
    end
    if (f > 0) chk("start_gap_ge2", 32'(gap >= 2), 1);
    chk("filter_sel", 32'(filter_sel), 32'(f));
    chk("weight_base", 32'(weight_base), 32'(f * KS));
    chk("busy_in_pass", 32'(busy), 1);
    chk("addr_pass_start", 32'(res_wr_addr), 32'(exp_addr));
    pix = 0;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        conv_latch_result = 1'b0;
        #1;
        chk("wr_en_idle", 32'(res_wr_en), 0);
        tick();
      end
      conv_latch_result = 1'b1;
      conv_final_done   = fd_last && (k == n - 1);
      #1;
      chk("wr_en", 32'(res_wr_en), 1);
      chk("wr_addr", 32'(res_wr_addr), 32'(exp_addr));
      if (pix < OMS) begin
        pix++;
        if (exp_addr < MAXA) exp_addr++;
      end else begin
        exp_err = 1'b1;
      end
      tick();
    end
    conv_latch_result = 1'b0;
    if (abort) return;
    if (!(fd_last && n > 0)) begin
      conv_final_done = 1'b1;
      tick();
    end
    if (pix != OMS) exp_err = 1'b1;
    chk("conv_start_released", 32'(conv_start), 0);
    chk("err_count_pass", 32'(err_count), 32'(exp_err));
    tick();
    chk("no_rearm_while_final_done", 32'(conv_start), 0);
    conv_final_done = 1'b0;
    gap = 2;
  endtask

  task automatic finish_layer();
    for (int i = 0; i < 10 && layer_done !== 1'b1; i++) tick();
    if (layer_done !== 1'b1) begin
      bound_fail("layer_done_wait");
      return;
    end
    chk("busy_in_done", 32'(busy), 1);
    tick();
    chk("layer_done_pulse_width", 32'(layer_done), 0);
    chk("busy_after_done", 32'(busy), 0);
    chk("conv_start_idle", 32'(conv_start), 0);
    chk("addr_final", 32'(res_wr_addr), 32'(exp_addr));
    chk("err_count_final", 32'(err_count), 32'(exp_err));
    chk("err_timeout", 32'(err_timeout), 0);
    chk("layer_done_count", 32'(done_cnt), 1);
  endtask

  initial begin
    reset             = 1'b1;
    start_layer       = 1'b0;
    conv_latch_result = 1'b0;
    conv_final_done   = 1'b0;
    pulse_en          = 1'b0;
    run_cyc           = 0;
    repeat (3) tick();
    chk("rst_conv_start", 32'(conv_start), 0);
    chk("rst_filter_sel", 32'(filter_sel), 0);
    chk("rst_weight_base", 32'(weight_base), 0);
    chk("rst_addr", 32'(res_wr_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_layer_done", 32'(layer_done), 0);
    chk("rst_err_count", 32'(err_count), 0);
    reset = 1'b0;
    tick();

    // Clean layer: 8 full passes, contiguous addresses
    start_run();
    for (int f = 0; f < NF; f++) run_pass(f, OMS, 1'b0, 1'b0);
    finish_layer();
    chk("clean_err", 32'(err_count), 0);

    // Short pass on filter 2
    start_run();
    for (int f = 0; f < NF; f++) run_pass(f, (f == 2) ? OMS - 1 : OMS, 1'b0, 1'b0);
    finish_layer();

    // Stray start pulses, coincident final_done, and overrun passes
    repeat (3) tick();
    run_cyc  = 5;
    pulse_en = 1'b1;
    start_run();
    for (int f = 0; f < NF; f++)
      run_pass(f, (f >= 6) ? OMS + 2 : OMS, (f == 0 || f == 7), 1'b0);
    finish_layer();
    pulse_en = 1'b0;
    repeat (5) tick();
    chk("no_queued_start_busy", 32'(busy), 0);
    chk("no_queued_start_conv", 32'(conv_start), 0);

    // Reset mid filter 4, then restart from scratch
    start_run();
    for (int f = 0; f < 4; f++) run_pass(f, OMS, 1'b0, 1'b0);
    run_pass(4, 100, 1'b0, 1'b1);
    reset             = 1'b1;
    conv_latch_result = 1'b1;
    tick();
    chk("mid_rst_conv_start", 32'(conv_start), 0);
    chk("mid_rst_filter_sel", 32'(filter_sel), 0);
    chk("mid_rst_weight_base", 32'(weight_base), 0);
    chk("mid_rst_addr", 32'(res_wr_addr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wr_en", 32'(res_wr_en), 0);
    chk("mid_rst_err_count", 32'(err_count), 0);
    reset             = 1'b0;
    conv_latch_result = 1'b0;
    tick();
    start_run();
    for (int f = 0; f < NF; f++) run_pass(f, OMS, 1'b0, 1'b0);
    finish_layer();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
